// File: rtl/uart_host_if.sv
// uart_host_if: register-bus link between uart_host (master) and the uart
// block (slave).
//   io_addr  : register address           (master -> slave)
//   io_wdata : write data                 (master -> slave)
//   io_write : write strobe               (master -> slave)
//   io_read  : read strobe                (master -> slave)
//   io_rdata : read data, same-cycle      (slave -> master)
//   uart_int : interrupt, rx ready | tx done (slave -> master)
interface uart_host_if;
  logic [3:0] io_addr;
  logic [7:0] io_wdata;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_rdata;
  logic       uart_int;

  modport master (
    output io_addr, io_wdata, io_write, io_read,
    input  io_rdata, uart_int
  );

  modport slave (
    input  io_addr, io_wdata, io_write, io_read,
    output io_rdata, uart_int
  );
endinterface

// File: rtl/uart_host.sv
// uart_host: owns the uart register bus and turns it into two byte streams.
// After reset it programs the baud divisor (regs 4/5). It then moves bytes
// from a TX FIFO into reg 1, one per tx-done handshake. On interrupt it polls
// status (reg 2), drains received bytes (reg 0) into an RX FIFO, and
// acknowledges tx-done by writing reg 2.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   tx_data/valid/ready   : inbound byte stream (into TX FIFO)
//   rx_data/valid/ready   : outbound byte stream (head of RX FIFO)
//   rx_overrun            : sticky, a received byte was dropped (RX FIFO full)
//   io                    : uart register bus (master side)
module uart_host #(
  parameter int unsigned DIV      = 43,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  uart_host_if.master io
);

  localparam logic [11:0]  DIV12 = 12'(DIV);
  localparam int unsigned  TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned  RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_ONE = {{RX_AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_DIVLO,
    S_DIVHI,
    S_IDLE,
    S_POLL,
    S_RXR,
    S_TXACK,
    S_TXW
  } state_t;

  state_t state, state_next;

  logic tx_idle;
  logic tx_idle_set, tx_idle_clr;

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr, tx_rd;
  logic           tx_empty, tx_full;
  logic           tx_push, tx_pop, tx_pop_req;
  logic [7:0]     tx_head;

  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr, rx_rd;
  logic           rx_empty, rx_full;
  logic           rx_push, rx_pop, rx_take;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TX_AW] != tx_rd[TX_AW]) &&
                    (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]);
  assign tx_head  = tx_mem[tx_rd[TX_AW-1:0]];

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RX_AW] != rx_rd[RX_AW]) &&
                    (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]);

  assign tx_ready = !tx_full && (state != S_DIVLO) && (state != S_DIVHI);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = tx_pop_req && !tx_empty;

  assign rx_valid = !rx_empty;
  assign rx_data  = rx_mem[rx_rd[RX_AW-1:0]];
  assign rx_pop   = rx_valid && rx_ready;
  // A full FIFO still accepts the new byte when the consumer frees a slot
  // in the same cycle.
  assign rx_push  = rx_take && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_DIVLO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    io.io_addr  = '0;
    io.io_wdata = '0;
    io.io_write = 1'b0;
    io.io_read  = 1'b0;
    tx_pop_req  = 1'b0;
    rx_take     = 1'b0;
    tx_idle_set = 1'b0;
    tx_idle_clr = 1'b0;
    case (state)
      S_DIVLO: begin
        io.io_write = 1'b1;
        io.io_addr  = 4'd4;
        io.io_wdata = DIV12[7:0];
        state_next  = S_DIVHI;
      end
      S_DIVHI: begin
        io.io_write = 1'b1;
        io.io_addr  = 4'd5;
        io.io_wdata = {4'b0000, DIV12[11:8]};
        state_next  = S_IDLE;
      end
      S_IDLE: begin
        // A byte being accepted this cycle counts as queued, so it reaches
        // the uart on the very next cycle; its slot is written at this edge
        // and is readable as the FIFO head in TXW.
        if (io.uart_int) begin
          state_next = S_POLL;
        end else if (tx_idle && (!tx_empty || tx_push)) begin
          state_next = S_TXW;
        end
      end
      S_POLL: begin
        io.io_read = 1'b1;
        io.io_addr = 4'd2;
        if (io.io_rdata[1]) begin
          state_next = S_RXR;
        end else if (io.io_rdata[0]) begin
          state_next = S_TXACK;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RXR: begin
        io.io_read = 1'b1;
        io.io_addr = 4'd0;
        rx_take    = 1'b1;
        state_next = S_IDLE;
      end
      S_TXACK: begin
        io.io_write = 1'b1;
        io.io_addr  = 4'd2;
        io.io_wdata = 8'h01;
        tx_idle_set = 1'b1;
        state_next  = S_IDLE;
      end
      S_TXW: begin
        io.io_write = 1'b1;
        io.io_addr  = 4'd1;
        io.io_wdata = tx_head;
        tx_pop_req  = 1'b1;
        tx_idle_clr = 1'b1;
        state_next  = S_IDLE;
      end
      default: begin
        state_next = S_DIVLO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_idle    <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      if (tx_idle_set) begin
        tx_idle <= 1'b1;
      end else if (tx_idle_clr) begin
        tx_idle <= 1'b0;
      end
      if (rx_take && rx_full && !rx_pop) begin
        rx_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TX_ONE;
      if (rx_push) rx_wr <= rx_wr + RX_ONE;
      if (rx_pop)  rx_rd <= rx_rd + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= io.io_rdata;
  end

endmodule

// File: doc/uart_host.md
Name: uart_host

Overview:
- Bus initiator that owns the UART's 4-bit io register interface, so the rest of the design talks to the UART through byte streams.
- Programs the baud divisor after reset.
- Streams TX bytes from a FIFO into the transmit-data register, one byte per transmit-done handshake.
- On interrupt, polls status, drains received bytes into an RX FIFO and acknowledges transmit-done.
- Sits between a byte-stream client (monitor/loader) and the uart block, wired port-to-port.

Parameters:
- DIV, 43, divisor loaded into UART regs 4/5 after reset (12 bits used; 20 MHz / 115200 / 4).
- TX_DEPTH, 4, TX FIFO entries (power of 2, >=2).
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data present
- tx_ready  out  1  TX FIFO not full; byte accepted when tx_valid&tx_ready
- rx_data  out  8  head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop RX head when rx_valid&rx_ready
- rx_overrun  out  1  sticky: received byte dropped, RX FIFO full
- io_addr  out  4  UART register address
- io_wdata  out  8  UART write data
- io_write  out  1  UART write strobe
- io_read  out  1  UART read strobe (reg 0 read clears rx interrupt)
- io_rdata  in  8  UART read data, combinational, valid same cycle as io_read
- uart_int  in  1  UART interrupt (rx ready | tx done)

Behaviour:
- UART map:
  - reg 0 read: rx byte, clears rx flag.
  - reg 1 write: tx byte.
  - reg 2 read: status, bit0 tx done, bit1 rx ready.
  - reg 2 write: bit0 clears tx done, bit1 clears rx.
  - regs 4/5: divisor low byte / high nibble.
- One bus operation per cycle at most.
- io_* are combinational decodes of state. When no access: io_read=0, io_write=0, io_addr=0, io_wdata=0.
- State machine (reset → DIVLO):
  - DIVLO: write reg4 = DIV[7:0] → DIVHI.
  - DIVHI: write reg5 = {4'b0, DIV[11:8]} → IDLE.
  - IDLE, no bus access, first match wins:
    - uart_int=1 → POLL.
    - else tx_idle=1 and TX FIFO non-empty → TXW.
    - else stay.
  - POLL: read reg2, sample io_rdata same cycle.
    - bit1 → RXR.
    - else bit0 → TXACK.
    - else → IDLE (spurious poll harmless).
  - RXR: read reg0.
    - RX FIFO not full → push io_rdata.
    - full → discard, rx_overrun<=1.
    - → IDLE.
  - TXACK: write reg2 = 8'h01, tx_idle<=1 → IDLE.
  - TXW: write reg1 = TX FIFO head, pop, tx_idle<=0 → IDLE.
- tx_idle is an internal flag, 1 at reset: the UART raises no tx-done after reset, so the first byte goes without waiting.
- RX takes priority over TX.
  - Status 8'h03 in POLL → RXR, then IDLE sees uart_int still high → POLL → TXACK.
- FIFOs: show-ahead, registered pointers with one extra wrap bit.
  - Full/empty from pointer compare.
  - Push and pop in the same cycle are both honoured, including RX push while full if the consumer pops that cycle.
  - tx_valid while full: ignored, no state change.
  - rx_ready while empty: ignored.
- Latency:
  - Byte accepted at cycle N (IDLE, tx_idle=1, FIFO empty) → TXW at N+1 → IDLE at N+2.
  - RXR at cycle M → rx_valid=1 at M+1.
- Reset values: tx_ready=0 during DIVLO/DIVHI and 1 after, rx_valid=0, rx_overrun=0, FIFOs empty, tx_idle=1, state DIVLO.
- Reset mid-operation: FIFO contents discarded, divisor reprogrammed. A byte already shifting in the UART is not tracked.
- rx_overrun clears only on reset.

Test Plan:
- Reset released → cycle 0: write reg4=0x2B; cycle 1: write reg5=0x00; then bus idle, tx_ready=1, rx_valid=0.
- Push 0x55 in IDLE at cycle N → io_write, io_addr=1, io_wdata=0x55 at N+1; no further reg1 write until uart_int → POLL reads 0x01 → TXACK writes reg2=0x01.
- Push 0x11, 0x22, 0x33 back-to-back → exactly three reg1 writes in order, each separated by one POLL+TXACK pair; tx_ready drops only with 4 unsent entries.
- UART rx flag set, UART holds 0xA5 → POLL reads 0x02, RXR reads reg0; next cycle rx_valid=1, rx_data=0xA5; rx_ready pops, rx_valid=0.
- rx_ready=0, five bytes 0x01..0x05 received → rx_valid=1, first four held in order, rx_overrun=1 after the fifth; drain yields 0x01..0x04.
- Status 0x03 (rx 0x7E and tx done together) → RXR before TXACK; then queued TX byte written. Asserting reset mid-stream → FIFOs empty and DIVLO/DIVHI writes repeat.
